ahblite_cmd_master: RTL and testbench

AHBLITE_CMD_MASTER -- requirements
Module: ahblite_cmd_master

---
 rtl/ahblite_cmd_master.sv | 116 +++++++++++
 tb/tb_ahblite_cmd_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_cmd_master.sv
// AHB-Lite single-transfer initiator: turns a valid/ready command stream into
// pipelined NONSEQ transfers and reports each completion as a one-cycle response.
module ahblite_cmd_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_NONSEQ = 2'b10
    } htrans_e;

    logic        a_valid;
    logic        a_write;
    logic [31:0] a_addr;
    logic [2:0]  a_size;
    logic [31:0] a_wdata;

    logic        d_valid;
    logic        d_write;
    logic [31:0] d_wdata;

    logic err_active;
    logic a_advance;
    logic d_done;
    logic accept;

    // Both error cycles see HRESP high with the data stage occupied; the
    // pending address is suppressed (IDLE) and kept until the error retires.
    assign err_active = d_valid & HRESP;
    assign a_advance  = a_valid & HREADY & ~err_active;
    assign d_done     = d_valid & HREADY;
    assign cmd_ready  = (~a_valid | HREADY) & ~err_active;
    assign accept     = cmd_valid & cmd_ready;

    assign HTRANS    = (a_valid & ~err_active) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = a_addr;
    assign HWRITE    = a_write;
    assign HSIZE     = a_size;
    assign HWDATA    = (d_valid & d_write) ? d_wdata : '0;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign busy      = a_valid | d_valid;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid   <= 1'b0;
            a_write   <= 1'b0;
            a_addr    <= '0;
            a_size    <= '0;
            a_wdata   <= '0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            d_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                a_valid <= 1'b1;
                a_write <= cmd_write;
                a_addr  <= cmd_addr;
                a_size  <= cmd_size;
                a_wdata <= cmd_wdata;
            end else if (a_advance) begin
                a_valid <= 1'b0;
            end

            if (HREADY) begin
                d_valid <= a_advance;
                if (a_advance) begin
                    d_write <= a_write;
                    d_wdata <= a_wdata;
                end
            end

            rsp_valid <= d_done;
            if (d_done) begin
                rsp_write <= d_write;
                rsp_err   <= HRESP;
                rsp_rdata <= d_write ? '0 : HRDATA;
            end

            if (d_done && HRESP && (err_count != '1)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahblite_cmd_master.sv
// Directed self-checking bench for ahblite_cmd_master; the bench plays the
// AHB responder cycle by cycle and checks bus and response timing.
module tb_ahblite_cmd_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;
    logic [7:0]  err_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned exp_cnt;

    ahblite_cmd_master dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] wd);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = wd;
    endtask

    initial begin
        HRESETn = 1'b0;
        set_cmd(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        HRDATA = 32'hDEAD_BEEF;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        settle;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_errcnt", 32'(err_count), 32'h0);
        check("rst_rspv", 32'(rsp_valid), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("const_hburst", 32'(HBURST), 32'h0);
        check("const_hprot", 32'(HPROT), 32'h3);
        check("const_lock", 32'(HMASTLOCK), 32'h0);
        repeat (2) tick;
        HRESETn = 1'b1;

        // zero-wait read
        set_cmd(1'b1, 1'b0, 32'h4, 3'd2, 32'h0);
        settle;
        check("rd_ready", 32'(cmd_ready), 32'h1);
        tick;
        cmd_valid = 1'b0;
        settle;
        check("rd_htrans_a", 32'(HTRANS), 32'h2);
        check("rd_haddr", HADDR, 32'h4);
        check("rd_hwrite", 32'(HWRITE), 32'h0);
        check("rd_hsize", 32'(HSIZE), 32'h2);
        check("rd_busy", 32'(busy), 32'h1);
        tick;
        HRDATA = 32'h3132_3334;
        settle;
        check("rd_htrans_d", 32'(HTRANS), 32'h0);
        check("rd_rspv_early", 32'(rsp_valid), 32'h0);
        tick;
        check("rd_rspv", 32'(rsp_valid), 32'h1);
        check("rd_rdata", rsp_rdata, 32'h3132_3334);
        check("rd_err", 32'(rsp_err), 32'h0);
        check("rd_rspw", 32'(rsp_write), 32'h0);
        check("rd_idle", 32'(busy), 32'h0);
        tick;
        check("rd_rspv_pulse", 32'(rsp_valid), 32'h0);

        // back-to-back zero-wait writes
        set_cmd(1'b1, 1'b1, 32'h8, 3'd2, 32'hAAAA_0001);
        tick;
        set_cmd(1'b1, 1'b1, 32'h4, 3'd2, 32'hBBBB_0002);
        settle;
        check("wr_htrans1", 32'(HTRANS), 32'h2);
        check("wr_haddr1", HADDR, 32'h8);
        check("wr_hwrite1", 32'(HWRITE), 32'h1);
        check("wr_ready2", 32'(cmd_ready), 32'h1);
        tick;
        cmd_valid = 1'b0;
        settle;
        check("wr_htrans2", 32'(HTRANS), 32'h2);
        check("wr_haddr2", HADDR, 32'h4);
        check("wr_hwdata1", HWDATA, 32'hAAAA_0001);
        check("wr_rspv0", 32'(rsp_valid), 32'h0);
        tick;
        check("wr_rspv1", 32'(rsp_valid), 32'h1);
        check("wr_rspw1", 32'(rsp_write), 32'h1);
        check("wr_rdata1", rsp_rdata, 32'h0);
        check("wr_hwdata2", HWDATA, 32'hBBBB_0002);
        check("wr_htrans3", 32'(HTRANS), 32'h0);
        tick;
        check("wr_rspv2", 32'(rsp_valid), 32'h1);
        check("wr_rspw2", 32'(rsp_write), 32'h1);
        check("wr_hwdata_clr", HWDATA, 32'h0);
        check("wr_idle", 32'(busy), 32'h0);
        tick;
        check("wr_rspv_end", 32'(rsp_valid), 32'h0);

        // read stretched by 3 wait states with a write queued behind it
        set_cmd(1'b1, 1'b0, 32'h10, 3'd2, 32'h0);
        tick;
        set_cmd(1'b1, 1'b1, 32'h14, 3'd2, 32'hCCCC_0003);
        settle;
        check("ws_ready_q", 32'(cmd_ready), 32'h1);
        tick;
        cmd_valid = 1'b0;
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle;
            check("ws_htrans", 32'(HTRANS), 32'h2);
            check("ws_haddr", HADDR, 32'h14);
            check("ws_hwdata", HWDATA, 32'h0);
            check("ws_ready", 32'(cmd_ready), 32'h0);
            check("ws_rspv", 32'(rsp_valid), 32'h0);
            tick;
        end
        HREADY = 1'b1;
        HRDATA = 32'h5A5A_1234;
        settle;
        check("ws_rspv_last", 32'(rsp_valid), 32'h0);
        tick;
        check("ws_rspv", 32'(rsp_valid), 32'h1);
        check("ws_rdata", rsp_rdata, 32'h5A5A_1234);
        check("ws_hwdata_q", HWDATA, 32'hCCCC_0003);
        check("ws_htrans_q", 32'(HTRANS), 32'h0);
        tick;
        check("ws_rspv_q", 32'(rsp_valid), 32'h1);
        check("ws_rspw_q", 32'(rsp_write), 32'h1);
        check("ws_rdata_q", rsp_rdata, 32'h0);
        tick;
        check("ws_rspv_end", 32'(rsp_valid), 32'h0);
        check("ws_idle", 32'(busy), 32'h0);

        // two-cycle error on the first of two queued commands
        set_cmd(1'b1, 1'b1, 32'h20, 3'd2, 32'hDDDD_0004);
        tick;
        set_cmd(1'b1, 1'b0, 32'h24, 3'd2, 32'h0);
        tick;
        cmd_valid = 1'b0;
        HREADY = 1'b0;
        HRESP  = 1'b1;
        settle;
        check("er1_htrans", 32'(HTRANS), 32'h0);
        check("er1_ready", 32'(cmd_ready), 32'h0);
        check("er1_haddr", HADDR, 32'h24);
        check("er1_hwdata", HWDATA, 32'hDDDD_0004);
        tick;
        HREADY = 1'b1;
        settle;
        check("er2_htrans", 32'(HTRANS), 32'h0);
        check("er2_ready", 32'(cmd_ready), 32'h0);
        check("er2_rspv", 32'(rsp_valid), 32'h0);
        tick;
        HRESP = 1'b0;
        settle;
        check("er_rspv", 32'(rsp_valid), 32'h1);
        check("er_rsperr", 32'(rsp_err), 32'h1);
        check("er_rspw", 32'(rsp_write), 32'h1);
        check("er_cnt", 32'(err_count), 32'h1);
        check("er_reissue", 32'(HTRANS), 32'h2);
        check("er_readdr", HADDR, 32'h24);
        tick;
        HRDATA = 32'hE0E0_0005;
        settle;
        check("er_rspv_gap", 32'(rsp_valid), 32'h0);
        check("er_htrans_d", 32'(HTRANS), 32'h0);
        tick;
        check("er_rspv2", 32'(rsp_valid), 32'h1);
        check("er_rsperr2", 32'(rsp_err), 32'h0);
        check("er_rdata2", rsp_rdata, 32'hE0E0_0005);
        check("er_cnt2", 32'(err_count), 32'h1);
        tick;

        // error counter saturation
        exp_cnt = 1;
        for (int i = 0; i < 256; i++) begin
            set_cmd(1'b1, 1'b1, 32'h30, 3'd2, 32'(i));
            tick;
            cmd_valid = 1'b0;
            tick;
            HREADY = 1'b0;
            HRESP  = 1'b1;
            tick;
            HREADY = 1'b1;
            tick;
            HRESP = 1'b0;
            settle;
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            check("sat_cnt", 32'(err_count), 32'(exp_cnt));
        end
        check("sat_ff", 32'(err_count), 32'hFF);
        tick;

        // reset during a wait-stated data phase
        set_cmd(1'b1, 1'b0, 32'h40, 3'd2, 32'h0);
        tick;
        set_cmd(1'b1, 1'b1, 32'h44, 3'd2, 32'hF00D_0006);
        tick;
        cmd_valid = 1'b0;
        HREADY = 1'b0;
        settle;
        check("mr_htrans_pre", 32'(HTRANS), 32'h2);
        check("mr_busy_pre", 32'(busy), 32'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mr_htrans", 32'(HTRANS), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_rspv", 32'(rsp_valid), 32'h0);
        check("mr_ready", 32'(cmd_ready), 32'h1);
        check("mr_errcnt", 32'(err_count), 32'h0);
        check("mr_haddr", HADDR, 32'h0);
        check("mr_hwdata", HWDATA, 32'h0);
        tick;
        HRESETn = 1'b1;
        HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle;
            check("mr_no_rsp", 32'(rsp_valid), 32'h0);
            check("mr_idle", 32'(busy), 32'h0);
            tick;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
